// File: rtl/pacman_color_gen_if.sv
// pacman_color_gen_if: pixel, sprite, palette-write and RGB signals of the colour generator
interface pacman_color_gen_if #(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W = 4,
  parameter int CB = 3
);
  logic pix_valid;
  logic pix_active;
  logic frame_start;
  logic [IDX_W-1:0] bg_code;
  logic [NUM_SPRITES-1:0] spr_hit;
  logic [NUM_SPRITES*IDX_W-1:0] spr_code;
  logic [NUM_SPRITES-1:0] spr_fright;
  logic pal_we;
  logic [IDX_W-1:0] pal_addr;
  logic [3*CB-1:0] pal_data;
  logic rgb_valid;
  logic [CB-1:0] red;
  logic [CB-1:0] green;
  logic [CB-1:0] blue;
  logic blank;
  modport master (
    output pix_valid, pix_active, frame_start, bg_code, spr_hit, spr_code, spr_fright,
    output pal_we, pal_addr, pal_data,
    input rgb_valid, red, green, blue, blank
  );
  modport slave (
    input pix_valid, pix_active, frame_start, bg_code, spr_hit, spr_code, spr_fright,
    input pal_we, pal_addr, pal_data,
    output rgb_valid, red, green, blue, blank
  );
endinterface

// File: rtl/pacman_color_gen.sv
// pacman_color_gen: sprite priority, frightened blink and palette lookup with 2-cycle registered RGB
module pacman_color_gen #(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W = 4,
  parameter int CB = 3,
  parameter int BLINK_FRAMES = 15,
  parameter logic [IDX_W-1:0] FRIGHT_IDX_A = 4'hC,
  parameter logic [IDX_W-1:0] FRIGHT_IDX_B = 4'hF
) (
  input logic clk,
  input logic rst,
  pacman_color_gen_if.slave b
);
  localparam int DEPTH = 1 << IDX_W;
  logic [3*CB-1:0] pal_q [DEPTH];
  logic [3*CB-1:0] pal_d [DEPTH];
  logic [7:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  logic s1_valid_q, s1_valid_d;
  logic s1_blank_q, s1_blank_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic rgb_valid_q, rgb_valid_d;
  logic blank_q, blank_d;
  logic [3*CB-1:0] rgb_q, rgb_d;
  logic win, win_fright, wrap;
  logic [IDX_W-1:0] win_code, pix_idx;
  // lowest-numbered visible sprite wins; scanning downward lets lower indices overwrite higher ones
  always_comb begin
    win = 1'b0;
    win_fright = 1'b0;
    win_code = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (b.spr_hit[i] && b.spr_code[i*IDX_W +: IDX_W] != '0) begin
        win = 1'b1;
        win_fright = b.spr_fright[i];
        win_code = b.spr_code[i*IDX_W +: IDX_W];
      end
  end
  // stage 1 index select; blink phase is the value held before this edge
  always_comb begin
    pix_idx = !b.pix_active ? '0 : !win ? b.bg_code :
              win_fright ? (phase_q ? FRIGHT_IDX_B : FRIGHT_IDX_A) : win_code;
    s1_valid_d = b.pix_valid;
    s1_blank_d = b.pix_valid ? !b.pix_active : s1_blank_q;
    s1_idx_d = b.pix_valid ? pix_idx : s1_idx_q;
  end
  // stage 2 lookup reads the palette before any same-edge write lands
  always_comb begin
    rgb_valid_d = s1_valid_q;
    blank_d = s1_valid_q && s1_blank_q;
    rgb_d = (s1_valid_q && !s1_blank_q) ? pal_q[s1_idx_q] : '0;
  end
  // frame counter wraps at BLINK_FRAMES and flips the blink phase
  always_comb begin
    wrap = cnt_q == 8'(BLINK_FRAMES - 1);
    cnt_d = !b.frame_start ? cnt_q : wrap ? 8'd0 : cnt_q + 8'd1;
    phase_d = phase_q ^ (b.frame_start && wrap);
  end
  // palette write port
  always_comb begin
    pal_d = pal_q;
    if (b.pal_we) pal_d[b.pal_addr] = b.pal_data;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_q <= '{default: '0};
      cnt_q <= '0;
      phase_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_idx_q <= '0;
      rgb_valid_q <= 1'b0;
      blank_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      pal_q <= pal_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_blank_q <= s1_blank_d;
      s1_idx_q <= s1_idx_d;
      rgb_valid_q <= rgb_valid_d;
      blank_q <= blank_d;
      rgb_q <= rgb_d;
    end
  end
  assign b.rgb_valid = rgb_valid_q;
  assign b.blank = blank_q;
  assign b.red = rgb_q[3*CB-1 -: CB];
  assign b.green = rgb_q[2*CB-1 -: CB];
  assign b.blue = rgb_q[CB-1:0];
endmodule

// File: doc/pacman_color_gen.md
Name: pacman_color_gen

Overview:
Parametrised pixel colour generator for the Pac-Man video path. It sits between the tile/sprite fetch logic and the VGA output pins. Each cycle it takes one background palette index and N sprite hits/indices for the current pixel, resolves sprite priority and transparency, and applies the frightened-ghost blink. It then looks the result up in a writable palette and drives registered RGB with a fixed 2-cycle latency.

Parameters:
NUM_SPRITES, 4, number of sprite layers; sprite 0 has highest priority.
IDX_W, 4, palette index width; palette depth is 2**IDX_W.
CB, 3, bits per colour channel.
BLINK_FRAMES, 15, frames per blink half-period; legal range 1..255.
FRIGHT_IDX_A, 4'hC, palette index for frightened ghosts, blink phase 0.
FRIGHT_IDX_B, 4'hF, palette index for frightened ghosts, blink phase 1.

Ports:
clk  in  1  system clock, single domain.
rst  in  1  synchronous reset, active-high.
pix_valid  in  1  pixel inputs are valid this cycle.
pix_active  in  1  pixel lies inside the visible area.
frame_start  in  1  one-cycle pulse, once per frame.
bg_code  in  IDX_W  background (maze/pellet) palette index.
spr_hit  in  NUM_SPRITES  sprite i covers this pixel.
spr_code  in  NUM_SPRITES*IDX_W  sprite i index in bits [i*IDX_W +: IDX_W].
spr_fright  in  NUM_SPRITES  sprite i is in frightened mode.
pal_we  in  1  palette write strobe.
pal_addr  in  IDX_W  palette write address.
pal_data  in  3*CB  write data as {R,G,B}.
rgb_valid  out  1  RGB outputs correspond to a valid input pixel.
red, green, blue  out  CB each  colour outputs.
blank  out  1  pixel was outside the visible area.

Behaviour:
- Reset (one clock with rst=1): every output is 0; all palette entries are 0; blink counter and blink_phase are 0; pipeline valids are cleared. Asserting reset mid-stream discards in-flight pixels, with no rgb_valid for them.
- Stage 1 (registered on the edge where pix_valid=1):
  - Winner is the lowest i where spr_hit[i]=1 and spr_code[i]!=0. Code 0 is transparent.
  - If there is no winner, index = bg_code.
  - If the winner has spr_fright[i]=1, index = FRIGHT_IDX_A when blink_phase=0, else FRIGHT_IDX_B.
  - If pix_active=0, index = 0 and the blank flag is set, regardless of hits.
  - Stage 1 uses the blink_phase value held before the current edge.
- Stage 2: palette read of the stage-1 index; red/green/blue, blank and rgb_valid are registered.
- Latency: pix_valid at edge N gives rgb_valid=1 at edge N+2. The pipeline accepts one pixel per cycle with no backpressure and no gaps required.
- When rgb_valid=0 or blank=1, red/green/blue are driven to 0. blank is meaningful only while rgb_valid=1; otherwise it is 0.
- Palette write: on an edge with pal_we=1, the entry is updated. A stage-2 lookup of the same address on that same edge returns the old value (read-before-write). Later lookups return the new value. Writes are legal at any time, including during active video.
- Blink counter:
  - Width is 8 bits; it increments on each frame_start.
  - On a frame_start that finds it at BLINK_FRAMES-1, it wraps to 0 and toggles blink_phase.
  - With BLINK_FRAMES=1, blink_phase toggles every frame.
  - frame_start is independent of pix_valid. A simultaneous frame_start and pix_valid pixel uses the old phase.
- Out-of-range parameter sets (NUM_SPRITES=0, FRIGHT_IDX_* >= 2**IDX_W) are unsupported.

Test Plan:
- Reset, then write palette[1]=9'o007 and palette[2]=9'o770. Drive one pixel with bg_code=1, no hits, pix_active=1 -> 2 cycles later rgb_valid=1, R=0, G=0, B=7, blank=0.
- Set spr_hit=4'b0110, codes sprite1=2 and sprite2=1, bg_code=1 -> R=7, G=7, B=0 (sprite 1 wins). Repeat with sprite1 code=0 -> sprite 2 shows, B=7.
- Set palette[12]=9'o700 and palette[15]=9'o777. Hold a sprite-0 frightened hit while pulsing frame_start 15 times -> colour changes from 7,0,0 to 7,7,7 exactly on the pixel after the 15th pulse, and back after the 30th.
- Drive pix_active=0 with a sprite hit -> rgb_valid=1, blank=1, RGB=0. Stream 100 back-to-back pixels -> 100 consecutive rgb_valid cycles at +2 latency.
- Write palette[1]=9'o111 on the same edge that a bg_code=1 pixel is in stage 2 -> old colour out. The next pixel gets 1,1,1.
- Assert rst for one cycle while two pixels are in flight -> no rgb_valid for them, all outputs 0, and palette[1] reads back as 0.
